static_multi_bit_sreg: RTL and testbench
========================================

Name: static_multi_bit_sreg

Overview:
- Static (fixed-length) multi-bit shift register with clock enable. DEPTH stages, each WIDTH bits wide.
- Shifts one stage on each rising clock edge where ce is high. so presents the oldest stage.
- General-purpose delay-line/pipeline element for datapaths that advance only on qualified cycles (e.g. sample strobes).

Parameters:
- DEPTH, 4, number of register stages (>=1); delay in enabled cycles from si to so.
- WIDTH, 4, bit width of each stage and of si/so (>=1).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge except reset.
- rst_n  input  1  asynchronous active-low reset; clears all stages.
- ce  input  1  clock enable / shift strobe; shift occurs only when high at posedge.
- si  input  WIDTH  serial (word-wide) input, sampled at posedge when ce=1.
- so  output  WIDTH  output of last stage (stage DEPTH-1), registered.

Behaviour:
- State: array stage[0..DEPTH-1], each WIDTH bits. stage[0] is the input end; stage[DEPTH-1] drives so.
- Reset: rst_n low immediately (asynchronously) forces every stage, and therefore so, to 0. Reset takes priority over ce.
- Stages stay 0 while rst_n is low. First shift is possible at the first posedge with rst_n high and ce=1.
- posedge clk, rst_n=1, ce=1: stage[0] <= si; stage[k] <= stage[k-1] for k=1..DEPTH-1.
- posedge clk, rst_n=1, ce=0: all stages hold, so unchanged. si is ignored.
- Latency: the word sampled on the Nth enabled edge appears on so immediately after the (N+DEPTH-1)th enabled edge. For DEPTH=1, so changes at the same edge si is sampled.
  - The delay is counted in enabled edges, not clock cycles. Any number of ce=0 cycles between enabled edges does not change the ordering or content of the data.
- so is a pure register output with no combinational path from si or ce.
- DEPTH=1: degenerates to a single enabled register.
- Continuous ce=1: behaves as a plain DEPTH-cycle delay line.
- Reset mid-operation: all in-flight words are discarded. After release, so is 0 until DEPTH enabled edges have shifted new data through.
- No overflow or underflow concept. Old data is simply shifted out and lost.
- Elaboration check: DEPTH<1 or WIDTH<1 is a fatal elaboration error.
- Synthesizable. No latches. Implementable as a generate-per-stage register chain or a packed array shift.

Test Plan:
- Reset: assert rst_n=0 mid-simulation while stages hold nonzero data -> so goes to 4'h0 without waiting for a clock edge. It stays 0 through 3 posedges with ce=1 after release with si=0.
- Sparse enable (DEPTH=4, WIDTH=4): pulse ce for 1 cycle every 4 cycles, presenting si=3,7,A,F,5 at successive pulses.
  - so becomes 3 right after the 4th pulse, then 7, A, F, 5 at the following pulses.
  - so is constant between pulses.
- Hold: ce=0 for 20 cycles with si toggling randomly -> so and all stages are unchanged.
- Continuous enable: ce=1 every cycle, si=1,2,3,...,F -> so equals si delayed by exactly 4 clock cycles.
- Reset during a stream: after 2 of 4 pending words are loaded, pulse rst_n low.
  - Those words never appear.
  - so=0 until the 4th enabled edge after release, when the first post-reset word appears.
- Random: 16 iterations of (3 idle cycles, 1 cycle ce=1, random si in 1..15), compared against a reference queue model of depth DEPTH -> exact match of so on every cycle.

Source files
------------

// File: rtl/static_multi_bit_sreg.sv
// Fixed-length, word-wide shift register that advances only on cycles with ce high.
// so is the oldest stage and comes straight from a flop.
module static_multi_bit_sreg #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] si,
  output logic [WIDTH-1:0] so
);

  if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
    $fatal(1, "static_multi_bit_sreg: DEPTH and WIDTH must both be >= 1");
  end

  // stage[0] is the input end, stage[DEPTH-1] is the output end.
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else if (ce) begin
      stage[0] <= si;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign so = stage[DEPTH-1];

endmodule

// File: tb/tb_static_multi_bit_sreg.sv
// Bench for static_multi_bit_sreg: table of hand-computed vectors, directed reset
// sequences and a randomised sparse-enable run checked against a queue model.
module tb_static_multi_bit_sreg;

  localparam int DEPTH = 4;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             ce;
  logic [WIDTH-1:0] si;
  logic [WIDTH-1:0] so;

  int total = 0;
  int bad   = 0;

  static_multi_bit_sreg #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .si    (si),
    .so    (so)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic             ce;
    logic [WIDTH-1:0] si;
    logic [WIDTH-1:0] exp_so;
  } vec_t;

  vec_t vecs [64];
  int   n_vec = 0;

  // reference model: exp_q[0] is the oldest word, i.e. the expected so
  logic [WIDTH-1:0] exp_q [$];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: so=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
  endtask

  task automatic add_vec(input logic c, input logic [WIDTH-1:0] s,
                         input logic [WIDTH-1:0] e);
    vecs[n_vec].ce     = c;
    vecs[n_vec].si     = s;
    vecs[n_vec].exp_so = e;
    n_vec++;
  endtask

  // driver: present inputs on the falling edge, sample result on the next falling edge
  task automatic step(input logic c, input logic [WIDTH-1:0] s);
    ce = c;
    si = s;
    @(posedge clk);
    if (c) begin
      void'(exp_q.pop_front());
      exp_q.push_back(s);
    end
    @(negedge clk);
  endtask

  // asynchronous reset pulse in the middle of a low clock phase, no edge seen
  task automatic mid_cycle_reset(input string name);
    ce = 1'b0;
    #2 rst_n = 1'b0;
    #1 check(name, so, '0);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] held;
  logic [WIDTH-1:0] w;

  initial begin
    // continuous enable 1..F: word from edge N shows after edge N+3
    for (int i = 1; i <= 15; i++)
      add_vec(1'b1, WIDTH'(i), (i >= 4) ? WIDTH'(i - 3) : '0);
    // sparse enable: one pulse every 4 cycles, idle si must be ignored
    add_vec(1'b1, 4'h3, 4'hD); add_vec(1'b0, 4'h6, 4'hD);
    add_vec(1'b0, 4'h9, 4'hD); add_vec(1'b0, 4'h1, 4'hD);
    add_vec(1'b1, 4'h7, 4'hE); add_vec(1'b0, 4'h6, 4'hE);
    add_vec(1'b0, 4'h9, 4'hE); add_vec(1'b0, 4'h1, 4'hE);
    add_vec(1'b1, 4'hA, 4'hF); add_vec(1'b0, 4'h6, 4'hF);
    add_vec(1'b0, 4'h9, 4'hF); add_vec(1'b0, 4'h1, 4'hF);
    add_vec(1'b1, 4'hF, 4'h3); add_vec(1'b0, 4'h6, 4'h3);
    add_vec(1'b0, 4'h9, 4'h3); add_vec(1'b0, 4'h1, 4'h3);
    add_vec(1'b1, 4'h5, 4'h7); add_vec(1'b0, 4'h6, 4'h7);
    add_vec(1'b0, 4'h9, 4'h7); add_vec(1'b0, 4'h1, 4'h7);
    add_vec(1'b1, 4'h0, 4'hA); add_vec(1'b0, 4'hC, 4'hA);
    add_vec(1'b1, 4'h0, 4'hF); add_vec(1'b0, 4'hC, 4'hF);
    add_vec(1'b1, 4'h0, 4'h5);

    rst_n = 1'b0;
    ce    = 1'b0;
    si    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", so, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_release", so, '0);

    for (int i = 0; i < n_vec; i++) begin
      step(vecs[i].ce, vecs[i].si);
      check($sformatf("vec%0d", i), so, vecs[i].exp_so);
    end

    // hold: stages now 0,0,0,5 from input end to output end
    held = so;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, WIDTH'($urandom_range(0, 15)));
      check("hold", so, held);
    end
    check("hold_model", so, exp_q[0]);

    // prime nonzero data everywhere, then asynchronous reset
    step(1'b1, 4'h9); step(1'b1, 4'h8); step(1'b1, 4'h7); step(1'b1, 4'h6);
    check("prime", so, 4'h9);
    mid_cycle_reset("async_reset");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h0);
      check("post_reset_zero", so, 4'h0);
    end

    // reset during a stream: B and C must never appear
    step(1'b1, 4'hB); step(1'b1, 4'hC);
    mid_cycle_reset("stream_reset");
    step(1'b1, 4'hD); check("stream_e1", so, 4'h0);
    step(1'b1, 4'hE); check("stream_e2", so, 4'h0);
    step(1'b0, 4'hB); check("stream_idle", so, 4'h0);
    step(1'b1, 4'h1); check("stream_e3", so, 4'h0);
    step(1'b1, 4'h2); check("stream_e4", so, 4'hD);
    step(1'b1, 4'h0); check("stream_e5", so, 4'hE);

    // random sparse enable against the queue model, checked every cycle
    for (int it = 0; it < 16; it++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b0, WIDTH'($urandom_range(0, 15)));
        check("rand_idle", so, exp_q[0]);
      end
      w = WIDTH'($urandom_range(1, 15));
      step(1'b1, w);
      check("rand_shift", so, exp_q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
